// File: rtl/instr_loader.sv
// Boot-time byte-stream instruction loader: frames START/END markers, packs 4 bytes
// MSB-first into 32-bit imem writes, holds the CPU in reset until done. Option: INSTR_LOADER_RELOAD_EN.
module instr_loader #(
    parameter int        IMEM_DEPTH = 64,
    parameter int        ADDR_W     = 6,
    parameter logic [7:0] START_BYTE = 8'hFE,
    parameter logic [7:0] END_BYTE   = 8'hFF
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [7:0]        instr_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_o,
    output logic              load_done_o,
    output logic              full_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] data_buf;

    // The next write address is the low bits of the word count, so it can never wrap
    // past the last word: the write to IMEM_DEPTH-1 also leaves LOAD.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state        <= IDLE;
            byte_idx     <= '0;
            data_buf     <= '0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            cpu_rst_o    <= 1'b1;
            load_done_o  <= 1'b0;
            full_o       <= 1'b0;
            word_count_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_i == START_BYTE) begin
                        state    <= LOAD;
                        byte_idx <= '0;
                    end
                end
                LOAD: begin
                    if (byte_idx == 2'd0 && instr_i == END_BYTE) begin
                        state       <= DONE;
                        cpu_rst_o   <= 1'b0;
                        load_done_o <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: data_buf[23:16] <= instr_i;
                            2'd1: data_buf[15:8]  <= instr_i;
                            2'd2: data_buf[7:0]   <= instr_i;
                            default: begin
                                imem_we_o    <= 1'b1;
                                imem_addr_o  <= word_count_o[ADDR_W-1:0];
                                imem_wdata_o <= {data_buf, instr_i};
                                word_count_o <= word_count_o + ONE;
                                if (word_count_o == LAST_WORD) begin
                                    state  <= DONE;
                                    full_o <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                DONE: begin
`ifdef INSTR_LOADER_RELOAD_EN
                    if (instr_i == START_BYTE) begin
                        state        <= LOAD;
                        byte_idx     <= '0;
                        cpu_rst_o    <= 1'b1;
                        load_done_o  <= 1'b0;
                        full_o       <= 1'b0;
                        word_count_o <= '0;
                    end else begin
                        cpu_rst_o   <= 1'b0;
                        load_done_o <= 1'b1;
                    end
`else
                    cpu_rst_o   <= 1'b0;
                    load_done_o <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader and CPU run sequencer. It sits between the external byte-wide instruction port (`instr_i`) and the CPU's instruction memory write port. It detects the start marker and assembles the following bytes into 32-bit words, writing them to consecutive instruction-memory addresses. It holds the CPU core in reset until the end marker arrives or memory fills, then releases it.

## Interface
- `IMEM_DEPTH`, 64, number of 32-bit instruction words; power of two, ≥ 2.
- `ADDR_W`, 6, instruction-memory word address width; must equal log2(`IMEM_DEPTH`).
- `START_BYTE`, 8'hFE, start-of-program marker.
- `END_BYTE`, 8'hFF, end-of-program marker.

- `clk_i` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `instr_i` input 8: byte stream, one byte sampled every cycle, no valid qualifier.
- `imem_we_o` output 1: one-cycle instruction-memory write strobe.
- `imem_addr_o` output `ADDR_W`: word address for the write.
- `imem_wdata_o` output 32: assembled instruction word.
- `cpu_rst_o` output 1: active-high hold-in-reset for the CPU core.
- `load_done_o` output 1: high while the program is loaded and the CPU is running.
- `full_o` output 1: sticky; load ended because `IMEM_DEPTH` words were written.
- `word_count_o` output `ADDR_W+1`: number of words written in the current load.

## Operation
- The FSM has three states: IDLE, LOAD, DONE.
- **IDLE**
  - Every byte is ignored except `START_BYTE`.
  - `instr_i == START_BYTE` → LOAD, with byte index = 0 and write address = 0.
- **LOAD**
  - Bytes are packed MSB first: byte index 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - At byte index 0, `instr_i == END_BYTE` → DONE. It is not written.
  - At byte index 0, any other value is taken as data, including 8'h00 and `START_BYTE`.
  - At byte indices 1–3, `END_BYTE` is ordinary data. Known limitation: a word whose top byte is 8'hFF cannot be loaded.
  - When byte index 3 is captured:
    - The full word is written at the current address.
    - The address increments and `word_count_o` increments.
    - The byte index returns to 0.
  - When the write to address `IMEM_DEPTH-1` is issued, the FSM goes to DONE and `full_o` is set. A following `END_BYTE` is ignored in DONE.
- **DONE**
  - `cpu_rst_o` = 0 and `load_done_o` = 1.
  - All bytes are ignored, subject to Configuration.
- The address never wraps. Writes beyond `IMEM_DEPTH-1` are impossible.
- `reset` in any state aborts the load:
  - A partial word is discarded.
  - Words already written stay in memory but are not tracked.
  - The next `START_BYTE` restarts at address 0.

## Timing
- Reset values:
  - State IDLE.
  - `imem_we_o` = 0.
  - `imem_addr_o` = 0, `imem_wdata_o` = 0.
  - `cpu_rst_o` = 1, `load_done_o` = 0, `full_o` = 0.
  - `word_count_o` = 0.
- Every output is registered. No combinational path runs from `instr_i` to any output.
- Write latency is 1 cycle:
  - `imem_we_o` is high for exactly the cycle after the edge that samples byte index 3.
  - `imem_addr_o` and `imem_wdata_o` are valid in that same cycle.
  - `imem_addr_o` and `imem_wdata_o` hold their values when `imem_we_o` is 0.
- `word_count_o` updates in the same cycle as the `imem_we_o` pulse.
- Release on end marker: `cpu_rst_o` falls and `load_done_o` rises in the cycle after the edge that samples `END_BYTE`. The last write therefore always completes before release.
- Release on full: `cpu_rst_o` falls one cycle after the final `imem_we_o` pulse.
- The minimum load is `START_BYTE` followed immediately by `END_BYTE`. Zero words are written and the CPU is released 2 cycles after the start-marker edge.
- Back-to-back words produce one `imem_we_o` pulse every 4 cycles.

## Configuration
- Macro: `INSTR_LOADER_RELOAD_EN`.
- Defined:
  - In DONE, `instr_i == START_BYTE` → LOAD.
  - In the cycle after that edge: `cpu_rst_o` = 1, `load_done_o` = 0, `full_o` = 0, `word_count_o` = 0, and the address restarts at 0.
- Undefined: DONE is terminal until `reset`, and all bytes, including `START_BYTE`, are ignored.

## Test plan
- **Basic load.** Stream 8'h00 ×3, FE, 00 50 00 93, 00 10 01 13, FF.
  - Expect two `imem_we_o` pulses, 4 cycles apart: addr 0 = 32'h00500093, addr 1 = 32'h00100113.
  - Then `word_count_o` = 2, `load_done_o` = 1, and `cpu_rst_o` falls 1 cycle after FF is sampled.
- **Pre-start noise.** Stream FF, 13, 00 before FE.
  - Expect no writes, state remains IDLE, `cpu_rst_o` = 1.
- **In-word markers.** After FE, stream 12 FF FE 56, then FF.
  - Expect one write of 32'h12FFFE56 at addr 0, then DONE.
- **Full.** With `IMEM_DEPTH` = 4, `ADDR_W` = 2, stream FE then 16 data bytes with no FF.
  - Expect 4 writes at addr 0–3, `full_o` = 1 and `cpu_rst_o` = 0 one cycle after the 4th pulse.
  - A subsequent byte stream causes no writes.
- **Reset mid-load.** After FE, AA, BB, assert `reset` for 1 cycle.
  - Expect all outputs at reset values and no write.
  - Then FE 01 02 03 04 FF writes 32'h01020304 at addr 0.
- **Reload.** From DONE, send FE 0A 0B 0C 0D FF.
  - With `INSTR_LOADER_RELOAD_EN`: `cpu_rst_o` goes back to 1, 32'h0A0B0C0D is written at addr 0, then the CPU is released again.
  - Without the macro: no write, `cpu_rst_o` stays 0.
